// File: rtl/jump_decode_ctrl_if.sv
// Program-counter / ROM / datapath side bundle for jump_decode_ctrl.
// master: the PC + ROM + datapath side; slave: the decoder itself.
interface jump_decode_ctrl_if;
    logic [7:0] ADDR;
    logic [7:0] INSTR;
    logic       ZERO_IN;
    logic       RESUME;
    logic       BRK_VALID;
    logic [7:0] BRK_ADDR;
    logic       JMP;
    logic [1:0] JMP_OFFSET;
    logic       ALU_EN;
    logic [5:0] ALU_CTRL;
    logic       HALTED;
    logic [4:0] LOOP_CNT;

    modport master (
        output ADDR, INSTR, ZERO_IN, RESUME, BRK_VALID, BRK_ADDR,
        input  JMP, JMP_OFFSET, ALU_EN, ALU_CTRL, HALTED, LOOP_CNT
    );

    modport slave (
        input  ADDR, INSTR, ZERO_IN, RESUME, BRK_VALID, BRK_ADDR,
        output JMP, JMP_OFFSET, ALU_EN, ALU_CTRL, HALTED, LOOP_CNT
    );
endinterface

// File: rtl/jump_decode_ctrl.sv
// Control-flow decoder sitting behind the program counter.
// Decodes the ROM word at ADDR with zero latency and tells the PC how to
// move on the next edge; owns the loop counter, zero flag and HALT state.
// Optional address breakpoint is built only when JUMP_DECODE_BRK_EN is defined.
module jump_decode_ctrl (
    input  logic                CLK,
    input  logic                RST_N,
    jump_decode_ctrl_if.slave   bus
);
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LDC  = 3'b001;
    localparam logic [2:0] OP_DJNZ = 3'b010;
    localparam logic [2:0] OP_JMP  = 3'b011;
    localparam logic [2:0] OP_JZ   = 3'b100;
    localparam logic [2:0] OP_HALT = 3'b101;

    localparam logic [1:0] OFF_HOLD = 2'b11;

    state_t     state_reg;
    logic [4:0] cnt_reg;
    logic       z_reg;
    logic       cause_brk;   // 1: halted by breakpoint, 0: halted by HALT opcode
    logic       brk_hit;

    logic [2:0] opcode;
    logic [4:0] operand;
    logic [1:0] off;
    logic [4:0] cnt_dec;

    logic       exec;        // instruction at ADDR is executed this cycle
    logic       jmp;
    logic [1:0] jmp_off;
    logic       alu_en;

    assign opcode  = bus.INSTR[7:5];
    assign operand = bus.INSTR[4:0];
    assign off     = bus.INSTR[1:0];
    assign cnt_dec = cnt_reg - 5'd1;

`ifdef JUMP_DECODE_BRK_EN
    logic cause_brk_reg;

    // A match only counts in RUN; the resume cycle is in HALT, which
    // naturally suppresses an immediate retrigger on the same address.
    assign brk_hit   = (state_reg == ST_RUN) && bus.BRK_VALID &&
                       (bus.ADDR == bus.BRK_ADDR);
    assign cause_brk = cause_brk_reg;

    // Remember why we halted: breakpoint wins over a HALT opcode.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cause_brk_reg <= 1'b0;
        end else if (brk_hit) begin
            cause_brk_reg <= 1'b1;
        end else if (exec) begin
            cause_brk_reg <= 1'b0;
        end
    end
`else
    logic unused_brk;

    // Without the breakpoint, ADDR and the breakpoint inputs carry no meaning here.
    assign unused_brk = ^{bus.ADDR, bus.BRK_VALID, bus.BRK_ADDR};
    assign brk_hit    = 1'b0;
    assign cause_brk  = 1'b0;
`endif

    // Zero-latency decode of the current instruction into PC and ALU controls.
    always_comb begin
        exec    = 1'b0;
        jmp     = 1'b0;
        jmp_off = 2'b00;
        alu_en  = 1'b0;
        if (!RST_N) begin
            exec = 1'b0;
        end else if (state_reg == ST_RUN) begin
            if (brk_hit) begin
                jmp     = 1'b1;
                jmp_off = OFF_HOLD;
            end else begin
                exec = 1'b1;
            end
        end else if (!bus.RESUME) begin
            jmp     = 1'b1;
            jmp_off = OFF_HOLD;
        end else if (cause_brk) begin
            // Resuming from a breakpoint: run the instruction we stopped on.
            exec = 1'b1;
        end
        // Resuming from a HALT opcode leaves jmp=0 so the PC steps past it.

        if (exec) begin
            case (opcode)
                OP_DJNZ: begin
                    if (cnt_dec != 5'd0) begin
                        jmp     = 1'b1;
                        jmp_off = off;
                    end
                end
                OP_JMP: begin
                    jmp     = 1'b1;
                    jmp_off = off;
                end
                OP_JZ: begin
                    jmp     = z_reg;
                    jmp_off = z_reg ? off : 2'b00;
                end
                OP_HALT: begin
                    jmp     = 1'b1;
                    jmp_off = OFF_HOLD;
                end
                3'b110, 3'b111: begin
                    alu_en = 1'b1;
                end
                default: begin
                    jmp = 1'b0;
                end
            endcase
        end
    end

    // Run/halt state machine together with loop counter and zero flag.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg <= ST_RUN;
            cnt_reg   <= 5'd0;
            z_reg     <= 1'b0;
        end else begin
            if (exec) begin
                case (opcode)
                    OP_LDC:         cnt_reg <= operand;
                    OP_DJNZ:        cnt_reg <= cnt_dec;
                    3'b110, 3'b111: z_reg   <= bus.ZERO_IN;
                    default:        cnt_reg <= cnt_reg;
                endcase
            end
            case (state_reg)
                ST_RUN: begin
                    if (brk_hit || opcode == OP_HALT) begin
                        state_reg <= ST_HALT;
                    end
                end
                ST_HALT: begin
                    if (bus.RESUME) begin
                        // A HALT opcode found on breakpoint resume halts again.
                        state_reg <= (exec && opcode == OP_HALT) ? ST_HALT : ST_RUN;
                    end
                end
                default: state_reg <= ST_RUN;
            endcase
        end
    end

    assign bus.JMP        = jmp;
    assign bus.JMP_OFFSET = jmp_off;
    assign bus.ALU_EN     = alu_en;
    assign bus.ALU_CTRL   = {bus.INSTR[5], bus.INSTR[4:0]};
    assign bus.HALTED     = (state_reg == ST_HALT);
    assign bus.LOOP_CNT   = cnt_reg;

    // OP_NOP is decoded implicitly by the default arms above.
    localparam logic [2:0] OP_NOP_REF = OP_NOP;
endmodule
